// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared RC4 constants, FSM state type and key-length clamp.
//  Revision    : 1.0
// ============================================================================
package rc4_pkg;

    localparam int RC4_N         = 256;
    localparam int KEY_BYTES_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_KSA       = 3'd2,
        ST_PRGA_SWAP = 3'd3,
        ST_PRGA_OUT  = 3'd4
    } rc4_state_e;

    // Lengths outside 1..4 fall back to the full 4-byte key.
    function automatic logic [2:0] clamp_len(input logic [7:0] len);
        if (len == 8'd0 || len > 8'(KEY_BYTES_MAX))
            return 3'(KEY_BYTES_MAX);
        return len[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_core_if
//  Description : Key/start request and keystream output bundle for rc4_core.
//  Revision    : 1.0
// ============================================================================
interface rc4_core_if;
    logic        start;
    logic [31:0] key;
    logic [7:0]  key_length;
    logic [7:0]  ckey;
    logic        done;

    modport master (output start, key, key_length, input ckey, done);
    modport slave  (input start, key, key_length, output ckey, done);
endinterface
`default_nettype wire

// File: rtl/rc4_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_sbox
//  Description : 256x8 flop state array with identity init, swap and 3 reads.
//  Revision    : 1.0
// ============================================================================
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       i_init,
    input  logic       i_swap,
    input  logic [7:0] i_addr_a,
    input  logic [7:0] i_addr_b,
    input  logic [7:0] i_addr_c,
    output logic [7:0] o_rd_a,
    output logic [7:0] o_rd_b,
    output logic [7:0] o_rd_c
);

    logic [7:0] r_s [RC4_N];

    assign o_rd_a = r_s[i_addr_a];
    assign o_rd_b = r_s[i_addr_b];
    assign o_rd_c = r_s[i_addr_c];

    // When a == b both branches carry the same value, so the swap degenerates cleanly.
    for (genvar n = 0; n < RC4_N; n++) begin : g_entry
        always_ff @(posedge clk) begin
            if (i_init)
                r_s[n] <= 8'(n);
            else if (i_swap && i_addr_a == 8'(n))
                r_s[n] <= o_rd_b;
            else if (i_swap && i_addr_b == 8'(n))
                r_s[n] <= o_rd_a;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rc4_core.sv
`default_nettype none
// ============================================================================
//  Module      : rc4_core
//  Description : RC4 key scheduling and keystream generation, one byte per 2 clocks.
//  Revision    : 1.0
// ============================================================================
module rc4_core
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    rc4_core_if.slave  bus
);

    rc4_state_e r_state, w_state_nxt;
    logic [7:0]  r_i, r_j, r_ckey;
    logic [1:0]  r_k;
    logic [2:0]  r_len;
    logic [31:0] r_key;
    logic        r_done;

    logic       w_init, w_swap;
    logic [7:0] w_i_inc, w_j_nxt, w_kbyte;
    logic [7:0] w_addr_a, w_addr_b, w_addr_c;
    logic [7:0] w_rd_a, w_rd_b, w_rd_c;

    always_comb begin
        case (r_k)
            2'd0:    w_kbyte = r_key[31:24];
            2'd1:    w_kbyte = r_key[23:16];
            2'd2:    w_kbyte = r_key[15:8];
            default: w_kbyte = r_key[7:0];
        endcase
    end

    // Port A reads S[i] (S[i+1] while swapping in PRGA); port B follows the new j.
    assign w_i_inc  = r_i + 8'd1;
    assign w_addr_a = (r_state == ST_PRGA_SWAP) ? w_i_inc : r_i;
    assign w_j_nxt  = r_j + w_rd_a + ((r_state == ST_KSA) ? w_kbyte : 8'd0);
    assign w_addr_b = (r_state == ST_PRGA_OUT) ? r_j : w_j_nxt;
    assign w_addr_c = w_rd_a + w_rd_b;

    rc4_sbox u_sbox (
        .clk      (clk),
        .i_init   (w_init),
        .i_swap   (w_swap),
        .i_addr_a (w_addr_a),
        .i_addr_b (w_addr_b),
        .i_addr_c (w_addr_c),
        .o_rd_a   (w_rd_a),
        .o_rd_b   (w_rd_b),
        .o_rd_c   (w_rd_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE:      w_state_nxt = ST_IDLE;
            ST_INIT: begin
                w_init      = 1'b1;
                w_state_nxt = ST_KSA;
            end
            ST_KSA: begin
                w_swap = 1'b1;
                if (r_i == 8'hFF)
                    w_state_nxt = ST_PRGA_SWAP;
            end
            ST_PRGA_SWAP: begin
                w_swap      = 1'b1;
                w_state_nxt = ST_PRGA_OUT;
            end
            ST_PRGA_OUT:  w_state_nxt = ST_PRGA_SWAP;
            default:      w_state_nxt = ST_IDLE;
        endcase
        if (bus.start) begin
            w_state_nxt = ST_INIT;
            w_init      = 1'b0;
            w_swap      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_k    <= 2'd0;
            r_key  <= 32'd0;
            r_len  <= 3'(KEY_BYTES_MAX);
            r_ckey <= 8'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.start) begin
                r_key <= bus.key;
                r_len <= clamp_len(bus.key_length);
            end else begin
                case (r_state)
                    ST_INIT: begin
                        r_i <= 8'd0;
                        r_j <= 8'd0;
                        r_k <= 2'd0;
                    end
                    ST_KSA: begin
                        r_i <= w_i_inc;
                        r_j <= (r_i == 8'hFF) ? 8'd0 : w_j_nxt;
                        r_k <= (({1'b0, r_k} + 3'd1) == r_len) ? 2'd0 : r_k + 2'd1;
                    end
                    ST_PRGA_SWAP: begin
                        r_i <= w_i_inc;
                        r_j <= w_j_nxt;
                    end
                    ST_PRGA_OUT: begin
                        r_ckey <= w_rd_c;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ckey = r_ckey;
    assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_rc4_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc4_core
//  Description : Scoreboard bench for rc4_core against an array-based RC4 model.
//  Revision    : 1.0
// ============================================================================
module tb_rc4_core;
    import rc4_pkg::*;

    typedef logic [7:0] bq_t [$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rc4_core_if bus ();
    rc4_core dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    int   start_cyc = 0;
    int   popped = 0;
    bit   first_pending = 1'b0;
    bq_t  exp_q;
    logic       prev_done = 1'b0;
    logic       prev_rst  = 1'b0;
    logic [7:0] prev_ckey = 8'd0;

    localparam logic [7:0] KEY_VEC  [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7,
                                             8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    localparam logic [7:0] WIKI_VEC [5]  = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Textbook RC4: KSA over S[], then PRGA, with plain integer arithmetic.
    task automatic ref_stream(input logic [31:0] key, input int len, input int n, output bq_t q);
        int s [256];
        int kb [4];
        int i, j, t, l;
        l = (len < 1 || len > 4) ? 4 : len;
        kb[0] = int'(key[31:24]); kb[1] = int'(key[23:16]);
        kb[2] = int'(key[15:8]);  kb[3] = int'(key[7:0]);
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + kb[x % l]) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        q = {};
        for (int x = 0; x < n; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            q.push_back(8'(s[(s[i] + s[j]) % 256]));
        end
    endtask

    // Known-answer head followed by model continuation so the stream never runs dry.
    task automatic build_exp(input logic [31:0] key, input int len, input bq_t head, output bq_t q);
        bq_t m;
        ref_stream(key, len, 80, m);
        q = head;
        for (int x = q.size(); x < 80; x++) q.push_back(m[x]);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (prev_done) check("done_back_to_back", 32'(prev_done & bus.done), 32'd0);
            if (first_pending) begin
                check("first_latency", 32'(cyc - start_cyc), 32'd259);
                first_pending = 1'b0;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                check("ckey", 32'(bus.ckey), 32'(exp_q.pop_front()));
                popped++;
            end
        end else if (rst_n && prev_rst) begin
            check("ckey_hold", 32'(bus.ckey), 32'(prev_ckey));
        end
        prev_done = bus.done;
        prev_ckey = bus.ckey;
        prev_rst  = rst_n;
    end

    task automatic do_start(input logic [31:0] key, input logic [7:0] len, input bq_t exp);
        @(negedge clk); #2;
        exp_q          = exp;
        popped         = 0;
        first_pending  = 1'b1;
        start_cyc      = cyc + 1;
        bus.key        = key;
        bus.key_length = len;
        bus.start      = 1'b1;
        @(negedge clk); #2;
        bus.start      = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int t = 0;
        while (popped < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        #1;
        if (popped < n) check("byte_timeout", 32'(popped), 32'(n));
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge clk); #2;
        rst_n = 1'b0;
        exp_q = {};
        first_pending = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk); #1;
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_ckey", 32'(bus.ckey), 32'd0);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bq_t q, head, none;
        logic [31:0] rk;
        logic [7:0]  rl;

        bus.start = 1'b1; bus.key = 32'h0; bus.key_length = 8'd0;
        apply_reset(3);
        @(negedge clk); #2;
        bus.start = 1'b0;

        head = {};
        foreach (KEY_VEC[x]) head.push_back(KEY_VEC[x]);
        build_exp(32'h4B657900, 3, head, q);
        do_start(32'h4B657900, 8'd3, q);
        wait_bytes(10, 400);

        head = {};
        foreach (WIKI_VEC[x]) head.push_back(WIKI_VEC[x]);
        build_exp(32'h57696B69, 4, head, q);
        do_start(32'h57696B69, 8'd4, q);
        wait_bytes(5, 400);
        do_start(32'h57696B69, 8'd0, q);
        wait_bytes(5, 400);
        do_start(32'h57696B69, 8'd9, q);
        wait_bytes(5, 400);

        // Restart mid-stream: "Key" for 3 bytes, then switch to "Wiki".
        head = {};
        foreach (KEY_VEC[x]) head.push_back(KEY_VEC[x]);
        build_exp(32'h4B657900, 3, head, q);
        do_start(32'h4B657900, 8'd3, q);
        wait_bytes(3, 400);
        head = {};
        foreach (WIKI_VEC[x]) head.push_back(WIKI_VEC[x]);
        build_exp(32'h57696B69, 4, head, q);
        do_start(32'h57696B69, 8'd4, q);
        wait_bytes(5, 400);

        // Reset during KSA: nothing may appear afterwards.
        do_start(32'h4B657900, 8'd3, q);
        repeat (100) @(negedge clk);
        apply_reset(1);
        repeat (300) @(negedge clk);
        #1;
        check("idle_after_rst_done", 32'(bus.done), 32'd0);
        check("idle_after_rst_ckey", 32'(bus.ckey), 32'd0);

        none = {};
        for (int r = 0; r < 6; r++) begin
            rk = $urandom;
            rl = 8'($urandom_range(0, 9));
            build_exp(rk, int'(rl), none, q);
            do_start(rk, rl, q);
            wait_bytes(64, 600);
        end

        apply_reset(2);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc4_core.md
# rc4_core

RC4 keystream generator: accepts a 1–4 byte key, runs the RC4 key-scheduling algorithm (KSA) over a 256-byte internal state array, then emits keystream bytes (PRGA) continuously until restarted or reset. It is a standalone crypto primitive. Downstream logic XORs `ckey` with data bytes, qualified by `done`.

## Interface
- Parameters: none; widths fixed (8-bit state, 256 entries, 32-bit key).
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: level-sampled each cycle; high restarts keying with current `key`/`key_length`.
- `key` in 32: key bytes, byte0 = `key[31:24]`, byte1 = `[23:16]`, byte2 = `[15:8]`, byte3 = `[7:0]`.
- `key_length` in 8: key length in bytes; valid 1..4; 0 or >4 treated as 4.
- `ckey` out 8: current keystream byte (registered, holds between strobes).
- `done` out 1: one-cycle strobe, new `ckey` valid.

## Operation
- State array S[0..255] (8-bit each), indices i, j (8-bit, mod-256 wrap), latched key bytes K[0..3], latched length L.
- FSM states: IDLE, INIT, KSA, PRGA_SWAP, PRGA_OUT.
- IDLE: waits for `start`.
- INIT (1 cycle): S[n]=n for all n in parallel; i=j=0; key counter k=0.
- KSA (256 cycles, one iteration per cycle): j = j + S[i] + K[k]; swap S[i], S[j]; i++; k = (k+1==L) ? 0 : k+1. Exit after i wraps 255→0, setting i=j=0, to PRGA_SWAP.
- PRGA_SWAP: i = i+1; j = j + S[i+1]; swap S[i+1], S[j_new].
- PRGA_OUT: ckey <= S[(S[i]+S[j]) mod 256] using post-swap S; done <= 1; next PRGA_SWAP.
- Stream runs indefinitely; no stop other than reset or `start`.
- `start` high in any state: latch key/L, go to INIT next cycle, `done` forced 0 that cycle; in-flight byte abandoned.
- Sums are 8-bit modulo 256; the i==j swap case is a no-op swap and must be correct.

## Timing
- Reset (`rst_n`=0 at edge): state IDLE, `ckey`=0, `done`=0, i=j=0; S contents don't-care until INIT. Reset mid-operation aborts immediately.
- `start` sampled at edge E0 → INIT performed at E1 → KSA at E2..E257 → PRGA_SWAP at E258 → `ckey`/`done` registered at E259.
- First `done` high in the cycle following E259; subsequent bytes every 2 cycles (done 1,0,1,0,...).
- `done` never high two consecutive cycles; `ckey` changes only on a done edge or reset.

## Structure
- Shared package `rc4_pkg`: FSM state enum, constants `RC4_N=256`, `KEY_BYTES_MAX=4`.
- S array as flop register file (2 read + 2 write ports per cycle) in sub-module `rc4_sbox` (parallel identity init, swap port, third read port for output index); FSM and index logic in `rc4_core`.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `start`=1 → `ckey`=0x00, `done`=0 throughout.
- Key "Key": `key`=32'h4B657900, `key_length`=3, pulse start → first `done` 259 edges after start; bytes EB 9F 77 81 B7 34 CA 72 A7 19.
- Key "Wiki": `key`=32'h57696B69, `key_length`=4 → bytes 60 44 DB 6D 41.
- Length clamp: `key_length`=0 and 9 with key 32'h57696B69 → identical stream to length 4 (60 44 DB ...).
- Restart mid-stream: after 3 "Key" bytes, pulse start with "Wiki" → no `done` until 259 edges later, then 60 44 DB ...; reset during KSA → IDLE, `done`=0.
- Strobe spacing: over 64 bytes `done` alternates exactly 1/0; `ckey` stable in non-done cycles.
